// File: rtl/vga_text_render.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_render
// Description : Text-mode pixel renderer. Looks up a 16-bit cell (glyph, fg,
//               bg) in an internal character RAM, fetches the glyph scanline
//               from an external font ROM, and emits 4-bit RGB plus sync,
//               all delayed by exactly four clocks. Blinking block cursor on
//               the bottom two scanlines of one selectable cell.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_render #(
   parameter int COLS = 160,
   parameter int ROWS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        disp,
   input  logic [10:0] x_pos,
   input  logic [9:0]  y_pos,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        wr_en,
   input  logic [13:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic        cursor_en,
   input  logic [7:0]  cursor_col,
   input  logic [5:0]  cursor_row,
   output logic [11:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int          DEPTH  = COLS * ROWS;
   localparam logic [13:0] COLS_W = 14'(COLS);

   // Character RAM: one write port, one registered read port, never reset
   logic [15:0] char_ram [0:DEPTH-1];

   // Cell coordinates of the incoming pixel
   logic [7:0]  cell_col;
   logic [5:0]  cell_row;
   logic [13:0] cell_addr;
   logic        cursor_hit;

   // Pipeline registers, suffix = stage number
   logic [13:0] addr1;
   logic [3:0]  scan1, scan2;
   logic [2:0]  xb1, xb2, xb3;
   logic        disp1, disp2, disp3;
   logic        hs1, hs2, hs3;
   logic        vs1, vs2, vs3;
   logic        hit1, hit2, cur3;
   logic [15:0] cell2;
   logic [3:0]  fg3, bg3;

   // Blink state
   logic [4:0]  blink_cnt;
   logic        vs_prev;

   // Final pixel colour
   logic        pix_bit;
   logic [3:0]  pix_colour;
   logic [11:0] rgb_next;

   // Expand {I,R,G,B} into three 4-bit channel levels
   function automatic logic [11:0] expand(input logic [3:0] c);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = c[3] ? 4'hF : 4'hA;
      lo = c[3] ? 4'h5 : 4'h0;
      return {(c[2] ? hi : lo), (c[1] ? hi : lo), (c[0] ? hi : lo)};
   endfunction

   assign cell_col  = x_pos[10:3];
   assign cell_row  = y_pos[9:4];
   assign cell_addr = {8'd0, cell_row} * COLS_W + {6'd0, cell_col};

   // An out-of-range cursor position is rejected outright so that it can
   // never alias a real cell through an out-of-range x coordinate.
   assign cursor_hit = cursor_en
                     && (cursor_col == cell_col)
                     && (cursor_row == cell_row)
                     && (y_pos[3:1] == 3'b111)
                     && (int'(cursor_col) < COLS)
                     && (int'(cursor_row) < ROWS);

   // Character RAM write, out-of-range addresses dropped
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
         char_ram[wr_addr] <= wr_data;
      end
   end

   // Stage 1: sample coordinates, sideband and cursor inputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr1 <= '0;
         scan1 <= '0;
         xb1   <= '0;
         disp1 <= 1'b0;
         hs1   <= 1'b0;
         vs1   <= 1'b0;
         hit1  <= 1'b0;
      end else begin
         addr1 <= cell_addr;
         scan1 <= y_pos[3:0];
         xb1   <= x_pos[2:0];
         disp1 <= disp;
         hs1   <= hs_in;
         vs1   <= vs_in;
         hit1  <= cursor_hit;
      end
   end

   // Stage 2: registered RAM read (old data on a same-cycle write)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cell2 <= '0;
         scan2 <= '0;
         xb2   <= '0;
         disp2 <= 1'b0;
         hs2   <= 1'b0;
         vs2   <= 1'b0;
         hit2  <= 1'b0;
      end else begin
         cell2 <= (int'(addr1) < DEPTH) ? char_ram[addr1] : 16'h0000;
         scan2 <= scan1;
         xb2   <= xb1;
         disp2 <= disp1;
         hs2   <= hs1;
         vs2   <= vs1;
         hit2  <= hit1;
      end
   end

   // Stage 3: issue font ROM address, split colours, gate cursor by blink
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         font_addr <= '0;
         fg3       <= '0;
         bg3       <= '0;
         xb3       <= '0;
         disp3     <= 1'b0;
         hs3       <= 1'b0;
         vs3       <= 1'b0;
         cur3      <= 1'b0;
      end else begin
         font_addr <= {cell2[7:0], scan2};
         fg3       <= cell2[11:8];
         bg3       <= cell2[15:12];
         xb3       <= xb2;
         disp3     <= disp2;
         hs3       <= hs2;
         vs3       <= vs2;
         cur3      <= hit2 & blink_cnt[4];
      end
   end

   // Font bit 7 is the leftmost pixel of the cell
   assign pix_bit    = font_data[~xb3];
   assign pix_colour = (pix_bit || cur3) ? fg3 : bg3;
   assign rgb_next   = disp3 ? expand(pix_colour) : 12'h000;

   // Stage 4: register RGB and the matching sync
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
         vga_hs <= 1'b0;
         vga_vs <= 1'b0;
      end else begin
         vga_r  <= rgb_next[11:8];
         vga_g  <= rgb_next[7:4];
         vga_b  <= rgb_next[3:0];
         vga_hs <= hs3;
         vga_vs <= vs3;
      end
   end

   // Frame counter for cursor blink, advanced on each vs_in rising edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_prev   <= 1'b0;
         blink_cnt <= '0;
      end else begin
         vs_prev <= vs_in;
         if (vs_in && !vs_prev) begin
            blink_cnt <= blink_cnt + 5'd1;
         end
      end
   end

endmodule
`default_nettype wire
